// File: rtl/mx_elastic_io_slice.sv
// Elastic retiming slice: CH independent valid/ready channels, STAGES skid stages each,
// plus a precision-config shadow that commits on drain. Define MX_SLICE_PERF_EN for perf counters.
module mx_elastic_io_slice #(
  parameter int CH     = 2,
  parameter int DATA_W = 264,
  parameter int STAGES = 1,
  parameter int CFG_W  = 4
) (
  input  logic                 clk_i,
  input  logic                 rstn,
  input  logic                 flush_i,
  input  logic [CH-1:0]        s_valid_i,
  output logic [CH-1:0]        s_ready_o,
  input  logic [CH*DATA_W-1:0] s_data_i,
  output logic [CH-1:0]        m_valid_o,
  input  logic [CH-1:0]        m_ready_i,
  output logic [CH*DATA_W-1:0] m_data_o,
  input  logic                 cfg_req_i,
  input  logic [CFG_W-1:0]     cfg_i,
  output logic [CFG_W-1:0]     cfg_o,
  output logic                 cfg_pending_o,
  output logic                 empty_o
`ifdef MX_SLICE_PERF_EN
  ,
  output logic [31:0]          stall_cnt_o,
  output logic [31:0]          beat_cnt_o
`endif
);

  // Handshake: a beat moves across any link on a rising edge where valid && ready.
  // valid never waits for ready; ready is always a flop output (no comb path back upstream).
  localparam int LNK = STAGES + 1;

  logic [CH*LNK-1:0]        lnk_valid;
  logic [CH*LNK-1:0]        lnk_ready;
  logic [CH*LNK*DATA_W-1:0] lnk_data;
  logic [CH*STAGES-1:0]     stage_busy;

  logic                     cfg_pending_q, cfg_pending_d;
  logic [CFG_W-1:0]         shadow_q, shadow_d;
  logic [CFG_W-1:0]         cfg_q, cfg_d;
  logic                     hs_any;
  logic                     commit;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    // A pending config hides valid from stage 0 so nothing new enters while draining.
    assign lnk_valid[c*LNK]                      = s_valid_i[c] & ~cfg_pending_q;
    assign lnk_data[c*LNK*DATA_W +: DATA_W]      = s_data_i[c*DATA_W +: DATA_W];
    assign s_ready_o[c]                          = lnk_ready[c*LNK] & ~cfg_pending_q;
    assign lnk_ready[c*LNK+STAGES]               = m_ready_i[c];
    assign m_valid_o[c]                          = lnk_valid[c*LNK+STAGES];
    assign m_data_o[c*DATA_W +: DATA_W]          = lnk_data[(c*LNK+STAGES)*DATA_W +: DATA_W];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int I = c*LNK + s;

      logic              main_v_q, main_v_d;
      logic              skid_v_q, skid_v_d;
      logic [DATA_W-1:0] main_d_q, main_d_d;
      logic [DATA_W-1:0] skid_d_q, skid_d_d;
      logic              in_valid;
      logic              out_ready;
      logic [DATA_W-1:0] in_data;

      assign in_valid                          = lnk_valid[I];
      assign in_data                           = lnk_data[I*DATA_W +: DATA_W];
      assign out_ready                         = lnk_ready[I+1];
      assign lnk_ready[I]                      = ~skid_v_q;
      assign lnk_valid[I+1]                    = main_v_q;
      assign lnk_data[(I+1)*DATA_W +: DATA_W]  = main_d_q;
      assign stage_busy[c*STAGES+s]            = main_v_q | skid_v_q;

      // The skid only fills while main is held; it always drains before main takes new input.
      always_comb begin
        main_v_d = main_v_q;
        main_d_d = main_d_q;
        skid_v_d = skid_v_q;
        skid_d_d = skid_d_q;
        if (skid_v_q) begin
          if (out_ready) begin
            main_d_d = skid_d_q;
            skid_v_d = 1'b0;
          end
        end else if (!main_v_q || out_ready) begin
          main_v_d = in_valid;
          if (in_valid) main_d_d = in_data;
        end else if (in_valid) begin
          skid_v_d = 1'b1;
          skid_d_d = in_data;
        end
        if (flush_i) begin
          main_v_d = 1'b0;
          skid_v_d = 1'b0;
        end
      end

      always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
          main_v_q <= 1'b0;
          skid_v_q <= 1'b0;
          main_d_q <= '0;
          skid_d_q <= '0;
        end else begin
          main_v_q <= main_v_d;
          skid_v_q <= skid_v_d;
          main_d_q <= main_d_d;
          skid_d_q <= skid_d_d;
        end
      end
    end
  end

  assign empty_o       = ~|stage_busy;
  assign hs_any        = |(s_valid_i & s_ready_o);
  assign commit        = cfg_pending_q & empty_o & ~hs_any & ~cfg_req_i;
  assign cfg_o         = cfg_q;
  assign cfg_pending_o = cfg_pending_q;

  // A request arriving in the commit cycle takes precedence; the older shadow never lands.
  always_comb begin
    cfg_pending_d = cfg_pending_q;
    shadow_d      = shadow_q;
    cfg_d         = cfg_q;
    if (cfg_req_i) begin
      shadow_d      = cfg_i;
      cfg_pending_d = 1'b1;
    end else if (commit) begin
      cfg_d         = shadow_q;
      cfg_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      cfg_pending_q <= 1'b0;
      shadow_q      <= '0;
      cfg_q         <= '0;
    end else begin
      cfg_pending_q <= cfg_pending_d;
      shadow_q      <= shadow_d;
      cfg_q         <= cfg_d;
    end
  end

`ifdef MX_SLICE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic        stall_ev;
  logic        beat_ev;

  assign stall_ev = |(m_valid_o & ~m_ready_i);
  assign beat_ev  = m_valid_o[0] & m_ready_i[0];

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    if (flush_i) begin
      stall_cnt_d = '0;
      beat_cnt_d  = '0;
    end else begin
      if (stall_ev && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
      if (beat_ev && (beat_cnt_q != '1))   beat_cnt_d  = beat_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
      beat_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign beat_cnt_o  = beat_cnt_q;
`endif

endmodule

// File: tb/tb_mx_elastic_io_slice.sv
// Self-checking bench for mx_elastic_io_slice (CH=2, STAGES=2): queue-based reference model
// checked every cycle, plus directed streaming, backpressure, config, flush and reset cases.
module tb_mx_elastic_io_slice;
  localparam int CH  = 2;
  localparam int DW  = 32;
  localparam int ST  = 2;
  localparam int CW  = 4;
  localparam int CAP = 2*ST;

  logic            clk_i;
  logic            rstn;
  logic            flush_i;
  logic [CH-1:0]   s_valid_i;
  logic [CH-1:0]   s_ready_o;
  logic [CH*DW-1:0] s_data_i;
  logic [CH-1:0]   m_valid_o;
  logic [CH-1:0]   m_ready_i;
  logic [CH*DW-1:0] m_data_o;
  logic            cfg_req_i;
  logic [CW-1:0]   cfg_i;
  logic [CW-1:0]   cfg_o;
  logic            cfg_pending_o;
  logic            empty_o;
`ifdef MX_SLICE_PERF_EN
  logic [31:0]     stall_cnt_o;
  logic [31:0]     beat_cnt_o;
`endif

  mx_elastic_io_slice #(.CH(CH), .DATA_W(DW), .STAGES(ST), .CFG_W(CW)) dut (
    .clk_i(clk_i), .rstn(rstn), .flush_i(flush_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .cfg_req_i(cfg_req_i), .cfg_i(cfg_i), .cfg_o(cfg_o),
    .cfg_pending_o(cfg_pending_o), .empty_o(empty_o)
`ifdef MX_SLICE_PERF_EN
    , .stall_cnt_o(stall_cnt_o), .beat_cnt_o(beat_cnt_o)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] exp_q [CH][$];
  int            acc_q [CH][$];
  logic [CW-1:0] cfg_m, shadow_m;
  logic          pend_m;
  int            acc_cnt [CH];
  int            out_cnt [CH];
  logic [DW-1:0] out_d0 [$];
  int            out_c0 [$];
  int            acc_c0 [$];
  bit            ev [CH];
  bit            all_empty;
  bit            hs_any;
  logic [31:0]   stall_m, beat_m;

  initial begin
    for (int c = 0; c < CH; c++) begin
      acc_cnt[c] = 0;
      out_cnt[c] = 0;
    end
  end

  always @(negedge clk_i) begin
    if (!rstn) begin
      for (int c = 0; c < CH; c++) begin
        exp_q[c].delete();
        acc_q[c].delete();
      end
      cfg_m = '0; shadow_m = '0; pend_m = 1'b0;
      stall_m = '0; beat_m = '0;
    end else begin
      all_empty = 1'b1;
      for (int c = 0; c < CH; c++) if (exp_q[c].size() != 0) all_empty = 1'b0;
      for (int c = 0; c < CH; c++) begin
        // A beat is visible exactly ST cycles after its accept, unless older beats are still ahead.
        ev[c] = 1'b0;
        if (exp_q[c].size() > 0) ev[c] = (cyc >= acc_q[c][0] + ST);
        chk($sformatf("m_valid%0d", c), m_valid_o[c], ev[c]);
        if (ev[c]) chk($sformatf("m_data%0d", c), m_data_o[c*DW +: DW], exp_q[c][0]);
        if (pend_m) chk($sformatf("s_ready_pend%0d", c), s_ready_o[c], 1'b0);
        else if (exp_q[c].size() == 0) chk($sformatf("s_ready_idle%0d", c), s_ready_o[c], 1'b1);
        if (exp_q[c].size() >= CAP) chk($sformatf("s_ready_full%0d", c), s_ready_o[c], 1'b0);
      end
      chk("empty", empty_o, all_empty);
      chk("cfg_o", cfg_o, cfg_m);
      chk("cfg_pending", cfg_pending_o, pend_m);
`ifdef MX_SLICE_PERF_EN
      chk("stall_cnt", stall_cnt_o, stall_m);
      chk("beat_cnt", beat_cnt_o, beat_m);
`endif
      hs_any = |(s_valid_i & s_ready_o);
      for (int c = 0; c < CH; c++) begin
        if (m_valid_o[c] && m_ready_i[c] && exp_q[c].size() > 0) begin
          void'(exp_q[c].pop_front());
          void'(acc_q[c].pop_front());
          out_cnt[c]++;
          if (c == 0) begin
            out_d0.push_back(m_data_o[DW-1:0]);
            out_c0.push_back(cyc);
          end
        end
        if (s_valid_i[c] && s_ready_o[c] && !flush_i) begin
          exp_q[c].push_back(s_data_i[c*DW +: DW]);
          acc_q[c].push_back(cyc);
          acc_cnt[c]++;
          if (c == 0) acc_c0.push_back(cyc);
        end
      end
      if (flush_i) begin
        for (int c = 0; c < CH; c++) begin
          exp_q[c].delete();
          acc_q[c].delete();
        end
        stall_m = '0;
        beat_m  = '0;
      end else begin
        if (((ev[0] && !m_ready_i[0]) || (ev[1] && !m_ready_i[1])) && stall_m != 32'hFFFF_FFFF)
          stall_m = stall_m + 32'd1;
        if (ev[0] && m_ready_i[0] && beat_m != 32'hFFFF_FFFF) beat_m = beat_m + 32'd1;
      end
      if (cfg_req_i) begin
        shadow_m = cfg_i;
        pend_m   = 1'b1;
      end else if (pend_m && all_empty && !hs_any) begin
        cfg_m  = shadow_m;
        pend_m = 1'b0;
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input int c, input logic [DW-1:0] d);
    int  n;
    bit  took;
    n = 0;
    s_valid_i[c] = 1'b1;
    s_data_i[c*DW +: DW] = d;
    do begin
      took = s_ready_o[c];
      tick();
      n++;
    end while (!took && n < 200);
    if (!took) fail_now($sformatf("send_ch%0d", c));
    s_valid_i[c] = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (!empty_o && n < 500) begin
      tick();
      n++;
    end
    if (!empty_o) fail_now(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int a0, o0, o1, n;
    rstn = 1'b0; flush_i = 1'b0; s_valid_i = '0; s_data_i = '0;
    m_ready_i = '0; cfg_req_i = 1'b0; cfg_i = '0;
    repeat (3) tick();
    chk("rst_s_ready", s_ready_o, 2'b11);
    chk("rst_m_valid", m_valid_o, 2'b00);
    chk("rst_m_data", m_data_o, 64'h0);
    chk("rst_cfg", cfg_o, 4'h0);
    chk("rst_pending", cfg_pending_o, 1'b0);
    chk("rst_empty", empty_o, 1'b1);
    rstn = 1'b1;
    tick();

    // Contiguous stream 0x01..0x10 on ch0 with free-running downstream
    m_ready_i = 2'b11;
    out_d0.delete(); out_c0.delete(); acc_c0.delete();
    for (int k = 1; k <= 16; k++) send(0, DW'(k));
    repeat (6) tick();
    chk("stream_count", out_d0.size(), 16);
    if (out_d0.size() >= 16 && acc_c0.size() >= 1) begin
      chk("stream_latency", out_c0[0] - acc_c0[0], 2);
      for (int i = 0; i < 16; i++) begin
        chk("stream_data", out_d0[i], i + 1);
        chk("stream_gap", out_c0[i] - out_c0[0], i);
      end
    end

    // Backpressure: ch0 stalled for 10 cycles with valid held
    m_ready_i = 2'b10;
    a0 = acc_cnt[0];
    s_valid_i[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_data_i[DW-1:0] = DW'(32'h100 + i);
      tick();
    end
    chk("bp_accepted", acc_cnt[0] - a0, 4);
    chk("bp_s_ready", s_ready_o[0], 1'b0);
    s_valid_i[0] = 1'b0;
    o0 = out_cnt[0];
    m_ready_i = 2'b11;
    repeat (8) tick();
    chk("bp_drained", out_cnt[0] - o0, 4);

    // Config request with 3 beats in flight
    m_ready_i = 2'b00;
    send(0, 32'h200); send(0, 32'h201); send(0, 32'h202);
    cfg_req_i = 1'b1; cfg_i = 4'hA;
    tick();
    cfg_req_i = 1'b0;
    chk("cfg_pend_set", cfg_pending_o, 1'b1);
    chk("cfg_block_ready", s_ready_o, 2'b00);
    repeat (2) tick();
    chk("cfg_block_hold", s_ready_o, 2'b00);
    chk("cfg_not_yet", cfg_o, 4'h0);
    m_ready_i = 2'b11;
    wait_empty("cfg_drain");
    chk("cfg_at_empty", cfg_o, 4'h0);
    tick();
    chk("cfg_commit", cfg_o, 4'hA);
    chk("cfg_pend_clr", cfg_pending_o, 1'b0);
    chk("cfg_ready_back", s_ready_o, 2'b11);

    // Flush with both channels full and a config pending
    m_ready_i = 2'b00;
    s_valid_i = 2'b11;
    for (int i = 0; i < 10; i++) begin
      s_data_i = {DW'(32'h300 + i), DW'(32'h400 + i)};
      tick();
    end
    s_valid_i = 2'b00;
    cfg_req_i = 1'b1; cfg_i = 4'h5;
    tick();
    cfg_req_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_m_valid", m_valid_o, 2'b00);
    chk("flush_empty", empty_o, 1'b1);
    chk("flush_keeps_pend", cfg_pending_o, 1'b1);
    tick();
    chk("flush_then_commit", cfg_o, 4'h5);
    chk("flush_ready_back", s_ready_o, 2'b11);
    // A beat presented during flush is dropped
    o1 = out_cnt[1];
    m_ready_i = 2'b11;
    s_valid_i[1] = 1'b1; s_data_i[DW +: DW] = 32'hDEAD;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; s_valid_i = 2'b00;
    repeat (4) tick();
    chk("flush_drop", out_cnt[1] - o1, 0);

    // Randomised traffic; ch0 stalls heavily, ch1 mostly flows
    o1 = out_cnt[1];
    for (int i = 0; i < 4000; i++) begin
      s_valid_i    = 2'($urandom_range(0, 3));
      s_data_i     = {32'($urandom), 32'($urandom)};
      m_ready_i[0] = ($urandom_range(0, 3) == 0);
      m_ready_i[1] = ($urandom_range(0, 3) != 0);
      cfg_req_i    = ($urandom_range(0, 99) == 0);
      cfg_i        = 4'($urandom_range(0, 15));
      flush_i      = ($urandom_range(0, 299) == 0);
      tick();
    end
    s_valid_i = 2'b00; cfg_req_i = 1'b0; flush_i = 1'b0; m_ready_i = 2'b11;
    wait_empty("rand_drain");
    chk("rand_ch1_progress", (out_cnt[1] - o1) > 500, 1'b1);
    repeat (3) tick();

`ifdef MX_SLICE_PERF_EN
    // 5 stall cycles then 8 channel-0 beats
    m_ready_i = 2'b10;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    send(0, 32'h500);
    n = 0;
    while (!m_valid_o[0] && n < 50) begin
      tick();
      n++;
    end
    if (!m_valid_o[0]) fail_now("perf_wait_valid");
    repeat (5) tick();
    m_ready_i = 2'b11;
    for (int k = 1; k < 8; k++) send(0, DW'(32'h500 + k));
    repeat (5) tick();
    chk("perf_stall_lit", stall_cnt_o, 32'd5);
    chk("perf_beat_lit", beat_cnt_o, 32'd8);
`endif

    // Reset asserted mid-stream
    cfg_req_i = 1'b1; cfg_i = 4'h3;
    tick();
    cfg_req_i = 1'b0;
    repeat (2) tick();
    chk("pre_rst_cfg", cfg_o, 4'h3);
    s_valid_i = 2'b11;
    m_ready_i = 2'b10;
    for (int i = 0; i < 5; i++) begin
      s_data_i = {DW'(32'h600 + i), DW'(32'h700 + i)};
      tick();
    end
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_s_ready", s_ready_o, 2'b11);
    chk("mid_rst_m_valid", m_valid_o, 2'b00);
    chk("mid_rst_m_data", m_data_o, 64'h0);
    chk("mid_rst_cfg", cfg_o, 4'h0);
    chk("mid_rst_pending", cfg_pending_o, 1'b0);
    chk("mid_rst_empty", empty_o, 1'b1);
    s_valid_i = 2'b00;
    repeat (2) tick();
    rstn = 1'b1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
